// File: rtl/midi_parameter_transmitter.sv
`default_nettype none
//------------------------------------------------------------------------------
// midi_parameter_transmitter
// Coalesces synth parameter updates and sends each as a 3-byte MIDI Control
// Change message on a 31250-baud 8N1 UART line.
// Revision: 1.0
//------------------------------------------------------------------------------
module midi_parameter_transmitter #(
  parameter int         CLKS_PER_BIT = 1600,
  parameter logic [3:0] MIDI_CHANNEL = 4'd0,
  parameter int         CC_TEMPO     = 20,
  parameter int         CC_UNISON    = 21,
  parameter int         CC_ATTACK    = 73,
  parameter int         CC_DECAY     = 75,
  parameter int         CC_SUSTAIN   = 22,
  parameter int         CC_RELEASE   = 72,
  parameter int         CC_VOLUME    = 7
) (
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic       param_valid,
  input  logic [2:0] param_id,
  input  logic [6:0] param_value,
  output logic       tx,
  output logic       busy,
  output logic [6:0] pending,
  output logic       message_sent
);

  localparam int            TW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] C_LAST_TICK = TW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   shift_q, shift_d;
  logic [6:0]    pending_q, pending_d;
  logic [6:0]    value_q [7];
  logic [6:0]    value_d [7];
  logic          sent_q, sent_d;

  logic          capture;
  logic          start_msg;
  logic          bit_end;
  logic [2:0]    sel_id;

  function automatic logic [6:0] cc_of(input logic [2:0] id);
    case (id)
      3'd0:    cc_of = 7'(CC_TEMPO);
      3'd1:    cc_of = 7'(CC_UNISON);
      3'd2:    cc_of = 7'(CC_ATTACK);
      3'd3:    cc_of = 7'(CC_DECAY);
      3'd4:    cc_of = 7'(CC_SUSTAIN);
      3'd5:    cc_of = 7'(CC_RELEASE);
      3'd6:    cc_of = 7'(CC_VOLUME);
      default: cc_of = 7'd0;
    endcase
  endfunction

  assign capture   = param_valid && (param_id != 3'd7);
  assign start_msg = (state_q == S_IDLE) && (pending_q != 7'd0);
  assign bit_end   = (timer_q == C_LAST_TICK);

  // Lowest pending index has priority.
  always_comb begin
    sel_id = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (pending_q[i]) sel_id = 3'(i);
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_msg) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = (byte_q == 2'd2) ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_START: tx   = 1'b0;
      S_DATA:  tx   = shift_q[0];
      default: ;
    endcase
  end

  assign pending      = pending_q;
  assign message_sent = sent_q;

  // Status byte sits in the low byte so the buffer simply shifts right, LSB first.
  always_comb begin
    timer_d   = timer_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    pending_d = pending_q;
    value_d   = value_q;
    sent_d    = 1'b0;

    if (state_q == S_IDLE) begin
      timer_d = '0;
      bit_d   = 3'd0;
      byte_d  = 2'd0;
      if (start_msg) begin
        shift_d = {1'b0, value_q[sel_id], 1'b0, cc_of(sel_id), 4'hB, MIDI_CHANNEL};
        pending_d[sel_id] = 1'b0;
      end
    end else if (bit_end) begin
      timer_d = '0;
      case (state_q)
        S_DATA: begin
          shift_d = {1'b0, shift_q[23:1]};
          bit_d   = bit_q + 3'd1;
        end
        S_STOP: begin
          if (byte_q == 2'd2) sent_d = 1'b1;
          else                byte_d = byte_q + 2'd1;
        end
        default: ;
      endcase
    end else begin
      timer_d = timer_q + TW'(1);
    end

    // Applied after the scheduler clear so a same-cycle update keeps the id dirty.
    if (capture) begin
      value_d[param_id]   = param_value;
      pending_d[param_id] = 1'b1;
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      timer_q   <= '0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      shift_q   <= 24'd0;
      pending_q <= 7'd0;
      sent_q    <= 1'b0;
      for (int i = 0; i < 7; i++) value_q[i] <= 7'd0;
    end else begin
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      pending_q <= pending_d;
      sent_q    <= sent_d;
      value_q   <= value_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_midi_parameter_transmitter.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_midi_parameter_transmitter
// Directed scoreboard bench: expected CC messages are queued at stimulus time
// and a UART decoder pops and compares each received message.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_midi_parameter_transmitter;

  localparam int CPB        = 16;
  localparam int MSG_CYCLES = 30 * CPB;

  logic       clk         = 1'b0;
  logic       reset_l     = 1'b0;
  logic       param_valid = 1'b0;
  logic [2:0] param_id    = 3'd0;
  logic [6:0] param_value = 7'd0;
  logic       tx;
  logic       busy;
  logic [6:0] pending;
  logic       message_sent;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int msgs   = 0;
  logic [23:0] exp_q[$];

  midi_parameter_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clock_50_000_000(clk),
    .reset_l         (reset_l),
    .param_valid     (param_valid),
    .param_id        (param_id),
    .param_value     (param_value),
    .tx              (tx),
    .busy            (busy),
    .pending         (pending),
    .message_sent    (message_sent)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic strobe(input logic [2:0] id, input logic [6:0] v);
    param_valid = 1'b1;
    param_id    = id;
    param_value = v;
    @(negedge clk);
    param_valid = 1'b0;
  endtask

  task automatic wait_sent(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (message_sent !== 1'b1 && n < bound);
    check("message_sent_seen", message_sent, 1);
  endtask

  // Decoder helpers: abort a frame if reset is observed.
  task automatic rx_wait(input int n, output bit ab);
    ab = 1'b0;
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk);
      if (reset_l !== 1'b1) ab = 1'b1;
    end
  endtask

  task automatic rx_wait_low(output bit ab);
    int n = 0;
    ab = 1'b0;
    while (tx !== 1'b0 && !ab) begin
      @(negedge clk);
      n++;
      if (reset_l !== 1'b1) ab = 1'b1;
      else if (n > 4 * CPB) begin
        check("inter_byte_gap", tx, 0);
        ab = 1'b1;
      end
    end
  endtask

  initial begin : monitor
    logic [7:0]  rb;
    logic [23:0] got;
    logic [23:0] expv;
    bit          ab;
    int          c0;
    int          n;
    forever begin
      @(negedge clk iff (reset_l === 1'b1 && tx === 1'b0));
      c0  = cyc;
      ab  = 1'b0;
      got = '0;
      for (int b = 0; b < 3 && !ab; b++) begin
        if (b > 0) rx_wait_low(ab);
        if (!ab) rx_wait(CPB / 2, ab);
        if (!ab) check("start_bit", tx, 0);
        for (int i = 0; i < 8 && !ab; i++) begin
          rx_wait(CPB, ab);
          rb[i] = tx;
        end
        if (!ab) rx_wait(CPB, ab);
        if (!ab) check("stop_bit", tx, 1);
        got = {got[15:0], rb};
      end
      if (!ab) begin
        n = 0;
        while (message_sent !== 1'b1 && n < 2 * CPB && reset_l === 1'b1) begin
          @(negedge clk);
          n++;
        end
        check("msg_duration", cyc - c0, MSG_CYCLES);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hFFFFFF;
        check("msg_bytes", got, expv);
        msgs++;
      end
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin : stimulus
    int lows;
    int busys;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_sent", message_sent, 0);
    reset_l = 1'b1;
    @(negedge clk);

    // Single volume message and 2-cycle latency
    exp_q.push_back(24'hB00764);
    strobe(3'd6, 7'h64);
    check("t1_pending_set", pending, 7'h40);
    check("t1_tx_still_idle", tx, 1);
    @(negedge clk);
    check("t1_tx_start", tx, 0);
    check("t1_busy", busy, 1);
    check("t1_pending_clr", pending, 0);
    wait_sent(MSG_CYCLES + 10);
    check("t1_busy_done", busy, 0);
    @(negedge clk);
    check("t1_stay_idle", busy, 0);
    check("t1_tx_high", tx, 1);

    // Coalescing while another message is in flight
    exp_q.push_back(24'hB01405);
    strobe(3'd0, 7'h05);
    repeat (3 * CPB) @(negedge clk);
    exp_q.push_back(24'hB04963);
    strobe(3'd2, 7'd10);
    strobe(3'd2, 7'd99);
    check("t2_pending_one", pending, 7'h04);
    wait_sent(MSG_CYCLES + 10);
    @(negedge clk);
    check("t2_next_busy", busy, 1);
    check("t2_pending_clr", pending, 0);
    repeat (5 * CPB) @(negedge clk);
    exp_q.push_back(24'hB04963);
    strobe(3'd2, 7'd10);
    repeat (3) @(negedge clk);
    strobe(3'd2, 7'd99);
    check("t2_pending_again", pending, 7'h04);
    wait_sent(MSG_CYCLES + 10);
    wait_sent(MSG_CYCLES + 10);
    check("t2_pending_end", pending, 0);
    @(negedge clk);
    check("t2_idle_end", busy, 0);

    // Ascending priority after the already-selected id
    exp_q.push_back(24'hB04811);
    exp_q.push_back(24'hB01422);
    exp_q.push_back(24'hB04B33);
    strobe(3'd5, 7'h11);
    strobe(3'd0, 7'h22);
    strobe(3'd3, 7'h33);
    check("t3_pending_09", pending, 7'h09);
    check("t3_busy", busy, 1);
    wait_sent(MSG_CYCLES + 10);
    check("t3_pending_at_sent1", pending, 7'h09);
    @(negedge clk);
    check("t3_pending_08", pending, 7'h08);
    wait_sent(MSG_CYCLES + 10);
    check("t3_pending_at_sent2", pending, 7'h08);
    @(negedge clk);
    check("t3_pending_00", pending, 0);
    check("t3_busy3", busy, 1);
    wait_sent(MSG_CYCLES + 10);
    @(negedge clk);
    check("t3_idle_end", busy, 0);

    // Update during byte 2 leaves snapshot intact, resend after 1 idle cycle
    exp_q.push_back(24'hB01510);
    strobe(3'd1, 7'h10);
    repeat (15 * CPB) @(negedge clk);
    exp_q.push_back(24'hB0157F);
    strobe(3'd1, 7'h7F);
    check("t4_pending", pending, 7'h02);
    wait_sent(MSG_CYCLES + 10);
    check("t4_gap_idle", busy, 0);
    check("t4_gap_pending", pending, 7'h02);
    @(negedge clk);
    check("t4_restart_busy", busy, 1);
    check("t4_restart_tx", tx, 0);
    check("t4_restart_pending", pending, 0);
    wait_sent(MSG_CYCLES + 10);
    @(negedge clk);

    // id 7 ignored; then sustain with zero value
    strobe(3'd7, 7'h55);
    lows  = 0;
    busys = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    check("t5_id7_tx_lows", lows, 0);
    check("t5_id7_busy", busys, 0);
    check("t5_id7_pending", pending, 0);
    exp_q.push_back(24'hB01600);
    strobe(3'd4, 7'h00);
    wait_sent(MSG_CYCLES + 10);
    @(negedge clk);

    // Reset mid-frame aborts; nothing resumes afterwards
    strobe(3'd3, 7'h2A);
    repeat (1 + 4 * CPB) @(negedge clk);
    check("t6_busy_before", busy, 1);
    reset_l = 1'b0;
    #1;
    check("t6_rst_tx", tx, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pending", pending, 0);
    check("t6_rst_sent", message_sent, 0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    lows  = 0;
    busys = 0;
    repeat (5 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    check("t6_quiet_tx", lows, 0);
    check("t6_quiet_busy", busys, 0);
    exp_q.push_back(24'hB00701);
    strobe(3'd6, 7'h01);
    wait_sent(MSG_CYCLES + 10);
    repeat (4) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    check("message_count", msgs, 11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/midi_parameter_transmitter.md
Name: midi_parameter_transmitter

Overview:
- Outbound half of the MIDI parameter path: encodes synth parameter updates as 3-byte MIDI Control Change messages and serializes them on a UART TX line (31250 baud, 8N1).
- Sits between the parameter store/front panel and the MIDI OUT pin, so external gear mirrors the synth's tempo, unison detune, ADSR and volume settings.
- Updates are coalesced per parameter: only the latest value is sent, and bursts are never lost.

Parameters:
- CLKS_PER_BIT, 1600, clock cycles per UART bit (50 MHz / 31250).
- MIDI_CHANNEL, 0, 4-bit channel placed in the status low nibble.
- CC_TEMPO, 20, controller number for id 0.
- CC_UNISON, 21, controller number for id 1.
- CC_ATTACK, 73, controller number for id 2.
- CC_DECAY, 75, controller number for id 3.
- CC_SUSTAIN, 22, controller number for id 4.
- CC_RELEASE, 72, controller number for id 5.
- CC_VOLUME, 7, controller number for id 6.

Ports:
- clock_50_000_000  input  1  system clock
- reset_l  input  1  asynchronous, active-low reset
- param_valid  input  1  one-cycle strobe: param_id/param_value valid
- param_id  input  3  0 tempo, 1 unison, 2 attack, 3 decay, 4 sustain, 5 release, 6 volume, 7 ignored
- param_value  input  7  new 7-bit parameter value
- tx  output  1  UART serial out, idle high
- busy  output  1  high while a message is being serialized
- pending  output  7  per-id dirty mask (bit i = id i awaiting transmission)
- message_sent  output  1  one-cycle pulse when the stop bit of byte 3 completes

Behaviour:
- Reset, asynchronous: tx=1, busy=0, pending=0, message_sent=0. Value registers, bit timer, bit and byte counters cleared. FSM to IDLE.
- Reset mid-frame aborts immediately; tx returns high and partial frames are not resumed.
- Capture:
  - param_valid with id 0..6 writes value_reg[id]=param_value and sets pending[id].
  - id 7 has no effect.
  - One capture per cycle.
- Coalescing: a repeat update to an already-pending id overwrites value_reg and leaves one pending bit, so only one message goes out with the latest value.
- Scheduler (IDLE only): when pending is nonzero, select the lowest set index.
  - Snapshot controller number and value_reg into a 3-byte shift buffer: {0xB0|MIDI_CHANNEL, 0|CC, 0|value}.
  - Clear that pending bit. Go to START; busy=1.
- Simultaneous clear and set of the same id: the set wins. pending[id] stays 1 with the new value, and that id is retransmitted after the current message.
- Updates during transmission never alter the in-flight snapshot.
- FSM states: IDLE, START, DATA, STOP.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - After STOP: if byte index<2, increment and go to START (bytes back-to-back, no gap). Otherwise pulse message_sent and go to IDLE.
  - busy drops in the IDLE cycle. A new message may start on the next cycle, so the minimum inter-message idle is 1 cycle.
- Latency: param_valid sampled at edge N sets pending at N; scheduler selects at N+1; tx falls after edge N+1 (2 cycles from strobe when idle).
- Message duration: exactly 30*CLKS_PER_BIT cycles of tx activity (48000 at default).
- Bit timer counts 0..CLKS_PER_BIT-1 with width $clog2(CLKS_PER_BIT). Byte counter is 2 bits; bit counter is 3 bits.
- No running status: every message carries its status byte.

Test Plan:
- Reset, then param_valid id=6 value=0x64 -> tx low 2 cycles after strobe. Decoded bytes 0xB0,0x07,0x64, each 1600 cycles/bit LSB-first. message_sent pulses once after 48000 cycles; busy=0 afterwards; pending=0.
- Strobe id=2 value=10, then next cycle id=2 value=99, both before selection -> one message 0xB0,0x49,0x63. Strobe id=2 value=10 during transmission, then id=2 value=99 -> second message carries 99 only.
- Strobe ids 5,0,3 on consecutive cycles while idle -> id5 message first (already selected). Then id0, then id3, in ascending order; pending shows remaining bits throughout.
- During byte 2 of an id=1 message, strobe id=1 value=0x7F -> current message unchanged. A second id=1 message with 0x7F follows after 1 idle cycle.
- Strobe id=7 -> no activity; tx stays 1, pending=0. Strobe id=4 value=0x80-masked input 0x00 -> status 0xB0, CC 0x16, value 0x00.
- Assert reset_l low mid-DATA of byte 1 -> tx=1 and busy=0 immediately. After release, no transmission until a new strobe.
